// File: rtl/pu_msp430_wakeup_pkg.sv
// Shared types and helpers for the MSP430 wakeup controller.
// Holds the FSM state type, channel limit and lowest-index priority encoder.
package pu_msp430_wakeup_pkg;

    localparam int WKUP_NCH_MAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wkup_state_e;

    // Returns the index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] wkup_prio_enc(
        input logic [WKUP_NCH_MAX-1:0] v
    );
        logic [3:0] idx;
        idx = '0;
        for (int i = WKUP_NCH_MAX - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pu_msp430_wakeup_ctrl_sync.sv
// Two-flop synchronizer cell with synchronous active-high reset.
// Ports: clk, rst, d (async level in), q (synchronized level out).
module pu_msp430_sync_cell (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pu_msp430_wakeup_ctrl.sv
// MSP430 wakeup controller: per-channel edge capture, pending/overflow flags
// and a two-state request FSM serving the lowest-index pending channel.
// Ports: mclk, puc_rst (sync, active-high); wkup_event/en/edge_sel/clear
// per channel; wkup_ack in; wkup_out, wkup_id, wkup_pend, wkup_ovf out.
// Option: define WAKEUP_SYNC_EN to put a 2-flop synchronizer on each input.
module pu_msp430_wakeup_ctrl
    import pu_msp430_wakeup_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input  logic           mclk,
    input  logic           puc_rst,
    input  logic [NCH-1:0] wkup_event,
    input  logic [NCH-1:0] wkup_en,
    input  logic [NCH-1:0] wkup_edge_sel,
    input  logic [NCH-1:0] wkup_clear,
    input  logic           wkup_ack,
    output logic           wkup_out,
    output logic [IDW-1:0] wkup_id,
    output logic [NCH-1:0] wkup_pend,
    output logic [NCH-1:0] wkup_ovf
);

    wkup_state_e state;
    wkup_state_e state_nxt;
    logic [IDW-1:0] id_nxt;

    logic [NCH-1:0] s;
    logic [NCH-1:0] s_d;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] set;
    logic [NCH-1:0] sel_mask;
    logic [NCH-1:0] ack_clr;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] pend_nxt;
    logic [NCH-1:0] ovf_nxt;
    logic [WKUP_NCH_MAX-1:0] pend_ext;
    logic primed;

`ifdef WAKEUP_SYNC_EN
    logic [2:0] prime_sr;

    for (genvar i = 0; i < NCH; i++) begin : g_sync
        pu_msp430_sync_cell u_sync (
            .clk (mclk),
            .rst (puc_rst),
            .d   (wkup_event[i]),
            .q   (s[i])
        );
    end

    // Hold off edge detection until the synchronizer pipeline and s_d
    // have filled, otherwise a level held across reset release would
    // look like a fresh edge two cycles later.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            prime_sr <= '0;
        end else begin
            prime_sr <= {prime_sr[1:0], 1'b1};
        end
    end

    assign primed = prime_sr[2];
`else
    assign s = wkup_event;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
        end
    end
`endif

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
    assign set  = ((wkup_edge_sel & rise) | (~wkup_edge_sel & fall))
                & wkup_en & {NCH{primed}};

    assign sel_mask = NCH'(1) << wkup_id;
    assign ack_clr  = (state == REQ && wkup_ack) ? sel_mask : '0;
    assign clr      = wkup_clear | ack_clr;

    // Set beats clear so an edge coinciding with ack/clear is kept.
    assign pend_nxt = (wkup_pend & ~clr) | set;
    assign ovf_nxt  = (wkup_ovf & ~wkup_clear)
                    | (set & wkup_pend & ~clr);

    assign pend_ext = WKUP_NCH_MAX'(wkup_pend);

    always_comb begin
        state_nxt = state;
        id_nxt    = wkup_id;
        unique case (state)
            IDLE: begin
                if (|wkup_pend) begin
                    state_nxt = REQ;
                    id_nxt    = IDW'(wkup_prio_enc(pend_ext));
                end
            end
            REQ: begin
                // Leaving on ack always passes through IDLE, which
                // guarantees the low gap between requests.
                if (wkup_ack || !(|(pend_nxt & sel_mask))) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state     <= IDLE;
            wkup_id   <= '0;
            wkup_out  <= 1'b0;
            wkup_pend <= '0;
            wkup_ovf  <= '0;
            s_d       <= '0;
        end else begin
            state     <= state_nxt;
            wkup_id   <= id_nxt;
            wkup_out  <= (state_nxt == REQ);
            wkup_pend <= pend_nxt;
            wkup_ovf  <= ovf_nxt;
            s_d       <= s;
        end
    end

endmodule

// File: tb/tb_pu_msp430_wakeup_ctrl.sv
// Self-checking bench for pu_msp430_wakeup_ctrl (NCH=4).
// Expected request IDs are queued at stimulus time and popped on wkup_out rise.
module tb_pu_msp430_wakeup_ctrl;

`ifdef WAKEUP_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       mclk;
    logic       puc_rst;
    logic [3:0] wkup_event;
    logic [3:0] wkup_en;
    logic [3:0] wkup_edge_sel;
    logic [3:0] wkup_clear;
    logic       wkup_ack;
    logic       wkup_out;
    logic [1:0] wkup_id;
    logic [3:0] wkup_pend;
    logic [3:0] wkup_ovf;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    logic prev_out = 1'b0;

    pu_msp430_wakeup_ctrl #(.NCH(4), .IDW(2)) dut (
        .mclk          (mclk),
        .puc_rst       (puc_rst),
        .wkup_event    (wkup_event),
        .wkup_en       (wkup_en),
        .wkup_edge_sel (wkup_edge_sel),
        .wkup_clear    (wkup_clear),
        .wkup_ack      (wkup_ack),
        .wkup_out      (wkup_out),
        .wkup_id       (wkup_id),
        .wkup_pend     (wkup_pend),
        .wkup_ovf      (wkup_ovf)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic ack_once();
        wkup_ack = 1'b1;
        step(1);
        wkup_ack = 1'b0;
    endtask

    // Scoreboard side: each new request must match the next queued ID.
    always @(negedge mclk) begin
        if (wkup_out && !prev_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                chk("req_id", int'(wkup_id), exp_q.pop_front());
            end
        end
        prev_out <= wkup_out;
    end

    initial begin
        puc_rst       = 1'b1;
        wkup_event    = 4'b0000;
        wkup_en       = 4'b1111;
        wkup_edge_sel = 4'b1111;
        wkup_clear    = 4'b0000;
        wkup_ack      = 1'b0;
        step(2);
        chk("rst_out", int'(wkup_out), 0);
        chk("rst_pend", int'(wkup_pend), 0);
        chk("rst_ovf", int'(wkup_ovf), 0);
        chk("rst_id", int'(wkup_id), 0);

        // Level held through reset release must not wake.
        wkup_event[0] = 1'b1;
        step(1);
        puc_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("prime_pend", int'(wkup_pend), 0);
            chk("prime_out", int'(wkup_out), 0);
        end
        wkup_event[0] = 1'b0;
        step(LAT + 2);
        chk("fall_ignored", int'(wkup_pend), 0);

        // Single rising edge on channel 2.
        wkup_event[2] = 1'b1;
        exp_q.push_back(2);
        step(LAT);
        chk("c2_pend", int'(wkup_pend), 4);
        chk("c2_out_early", int'(wkup_out), 0);
        step(1);
        chk("c2_out", int'(wkup_out), 1);
        chk("c2_id", int'(wkup_id), 2);
        wkup_event[2] = 1'b0;
        ack_once();
        chk("c2_ack_out", int'(wkup_out), 0);
        chk("c2_ack_pend", int'(wkup_pend), 0);
        step(LAT + 1);
        chk("c2_quiet", int'(wkup_pend), 0);

        // Channels 1 and 3 together: lowest index first.
        wkup_event[1] = 1'b1;
        wkup_event[3] = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(3);
        step(LAT);
        chk("prio_pend", int'(wkup_pend), 10);
        step(1);
        chk("prio_id1", int'(wkup_id), 1);
        ack_once();
        chk("prio_gap", int'(wkup_out), 0);
        chk("prio_pend3", int'(wkup_pend), 8);
        step(1);
        chk("prio_out3", int'(wkup_out), 1);
        chk("prio_id3", int'(wkup_id), 3);
        ack_once();
        chk("prio_done", int'(wkup_pend), 0);
        wkup_event[1] = 1'b0;
        wkup_event[3] = 1'b0;
        step(LAT + 1);

        // Overflow on channel 0, then explicit clear drops the request.
        wkup_event[0] = 1'b1;
        exp_q.push_back(0);
        step(LAT);
        chk("ovf_pend", int'(wkup_pend), 1);
        wkup_event[0] = 1'b0;
        step(1);
        chk("ovf_out", int'(wkup_out), 1);
        wkup_event[0] = 1'b1;
        step(LAT);
        chk("ovf_set", int'(wkup_ovf), 1);
        chk("ovf_pend2", int'(wkup_pend), 1);
        wkup_clear = 4'b0001;
        step(1);
        wkup_clear = 4'b0000;
        chk("clr_pend", int'(wkup_pend), 0);
        chk("clr_ovf", int'(wkup_ovf), 0);
        chk("clr_idle", int'(wkup_out), 0);
        step(2);
        chk("clr_stay", int'(wkup_out), 0);
        wkup_event[0] = 1'b0;
        step(LAT + 1);

        // Ack coinciding with a new edge on the served channel.
        wkup_event[1] = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(1);
        step(LAT);
        wkup_event[1] = 1'b0;
        step(1);
        chk("race_out", int'(wkup_out), 1);
        wkup_event[1] = 1'b1;
        step(LAT - 1);
        ack_once();
        chk("race_pend", int'(wkup_pend), 2);
        chk("race_gap", int'(wkup_out), 0);
        step(1);
        chk("race_reassert", int'(wkup_out), 1);
        chk("race_id", int'(wkup_id), 1);
        ack_once();
        chk("race_done", int'(wkup_pend), 0);
        wkup_event[1] = 1'b0;
        step(LAT + 1);

        // Falling-edge select on channel 1.
        wkup_edge_sel = 4'b1101;
        wkup_event[1] = 1'b1;
        step(LAT + 1);
        chk("fall_rise_ign", int'(wkup_pend), 0);
        wkup_event[1] = 1'b0;
        exp_q.push_back(1);
        step(LAT);
        chk("fall_pend", int'(wkup_pend), 2);
        step(1);
        chk("fall_id", int'(wkup_id), 1);
        ack_once();
        chk("fall_done", int'(wkup_pend), 0);

        // Disabled channel does not capture.
        wkup_en = 4'b1101;
        wkup_event[1] = 1'b1;
        step(LAT + 1);
        wkup_event[1] = 1'b0;
        step(LAT + 1);
        chk("dis_pend", int'(wkup_pend), 0);
        chk("dis_out", int'(wkup_out), 0);
        wkup_en = 4'b1111;
        wkup_edge_sel = 4'b1111;

        // Disabling keeps an already pending bit.
        wkup_event[2] = 1'b1;
        exp_q.push_back(2);
        step(LAT);
        wkup_en = 4'b1011;
        step(1);
        chk("en_keep_pend", int'(wkup_pend), 4);
        chk("en_keep_id", int'(wkup_id), 2);
        ack_once();
        chk("en_keep_done", int'(wkup_pend), 0);
        wkup_en = 4'b1111;
        wkup_event[2] = 1'b0;
        step(LAT + 1);

        // Reset during an active request.
        wkup_event[3] = 1'b1;
        exp_q.push_back(3);
        step(LAT + 1);
        chk("rreq_out", int'(wkup_out), 1);
        puc_rst = 1'b1;
        step(1);
        chk("rreq_drop", int'(wkup_out), 0);
        chk("rreq_pend", int'(wkup_pend), 0);
        chk("rreq_id", int'(wkup_id), 0);
        puc_rst = 1'b0;
        step(LAT + 3);
        chk("rreq_after", int'(wkup_pend), 0);
        chk("rreq_after_out", int'(wkup_out), 0);
        wkup_event[3] = 1'b0;
        step(LAT + 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pu_msp430_wakeup_ctrl.md
PU_MSP430_WAKEUP_CTRL -- requirements
Module: pu_msp430_wakeup_ctrl

Interface
REQ-001 The block SHALL have one clock, mclk; reset SHALL be puc_rst, synchronous and active-high.
REQ-002 Parameter NCH, default 4, SHALL set the number of wakeup channels (legal 1..16).
REQ-003 Parameter IDW, default 2, SHALL set the channel-ID width; it SHALL equal max(1, ceil(log2(NCH))).
REQ-004 Port mclk, input, 1 bit, SHALL be the system clock.
REQ-005 Port puc_rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port wkup_event, input, NCH bits, SHALL carry the raw level wakeup sources.
REQ-007 Port wkup_en, input, NCH bits, SHALL be the per-channel capture enable.
REQ-008 Port wkup_edge_sel, input, NCH bits, SHALL select the active edge per channel (1 = rising, 0 = falling).
REQ-009 Port wkup_clear, input, NCH bits, SHALL be a one-cycle pulse that clears the pending and overflow bits of the selected channels.
REQ-010 Port wkup_ack, input, 1 bit, SHALL be the consumer acknowledge of the current request.
REQ-011 Port wkup_out, output, 1 bit, SHALL be the wakeup request.
REQ-012 Port wkup_id, output, IDW bits, SHALL give the channel being served.
REQ-013 Port wkup_pend, output, NCH bits, SHALL give the pending flags.
REQ-014 Port wkup_ovf, output, NCH bits, SHALL give the sticky overflow flags.

Function
REQ-015 Each channel SHALL keep a sampled level s and a history flop s_d. A rising edge SHALL be s & ~s_d; a falling edge SHALL be ~s & s_d; the edge used SHALL be chosen by wkup_edge_sel.
REQ-016 A selected edge with wkup_en=1 SHALL set wkup_pend[i] on the next mclk edge. wkup_en=0 SHALL block new captures but SHALL NOT clear existing pending bits.
REQ-017 When a set and a clear (wkup_clear or ack-clear) hit the same bit in the same cycle, the set SHALL win; no event is ever lost.
REQ-018 An enabled edge on a channel whose pending bit is already 1 and is not cleared that cycle SHALL set wkup_ovf[i]; wkup_ovf[i] SHALL be cleared only by wkup_clear[i].
REQ-019 The FSM SHALL have two states, IDLE and REQ.
REQ-020 In IDLE with wkup_pend != 0, the FSM SHALL go to REQ on the next edge and latch wkup_id as the lowest-index pending channel.
REQ-021 In REQ, wkup_out SHALL be 1 and wkup_id SHALL hold stable until acknowledged.
REQ-022 A wkup_ack in REQ SHALL clear wkup_pend[wkup_id] (subject to REQ-017) and return the FSM to IDLE. wkup_ack in IDLE SHALL be ignored.
REQ-023 After an ack, wkup_out SHALL be 0 for at least one cycle before the next request.
REQ-024 If wkup_clear removes the served channel's pending bit while in REQ, the FSM SHALL return to IDLE on the next edge without waiting for ack.
REQ-025 wkup_out SHALL be a direct flop output and SHALL be glitch-free.

Reset
REQ-026 With puc_rst=1, the FSM SHALL be IDLE and wkup_out, wkup_id, wkup_pend, wkup_ovf, the synchronizers and s_d SHALL all be 0.
REQ-027 A primed flag SHALL be 0 in reset and set on the first cycle after reset. Edges SHALL be ignored while primed=0, so levels present at reset release do not produce spurious wakeups.
REQ-028 Reset during REQ SHALL drop the request and all pending state within the same edge.

Configuration
REQ-029 Macro WAKEUP_SYNC_EN, when defined, SHALL insert a 2-flop synchronizer per channel ahead of s. With it, an input change SHALL reach wkup_pend on the 3rd mclk edge and wkup_out on the 4th.
REQ-030 Without WAKEUP_SYNC_EN, s SHALL be wkup_event directly (input must be mclk-synchronous). Latency SHALL then be 1 edge to wkup_pend and 2 edges to wkup_out.

Structure
REQ-031 Package pu_msp430_wakeup_pkg SHALL hold the FSM state typedef (IDLE, REQ), the constant WKUP_NCH_MAX=16, and the lowest-index priority-encode function.
REQ-032 The synchronizer SHALL be sub-module pu_msp430_sync_cell (2 flops, synchronous reset), instantiated NCH times under WAKEUP_SYNC_EN.

Verification
REQ-033 NCH=4, sync on, all enabled, rising selected; pulse wkup_event[2] 0->1 -> wkup_pend=4'b0100 on edge 3, wkup_out=1 and wkup_id=2 on edge 4; ack -> wkup_out=0, wkup_pend=0.
REQ-034 Rising edges on channels 1 and 3 in the same cycle -> wkup_id=1 first; after ack, 1 idle cycle, then wkup_id=3.
REQ-035 wkup_event[0] held high through reset release -> no pending bit and wkup_out stays 0 for 10 cycles.
REQ-036 Channel 0 pending, second rising edge -> wkup_ovf=4'b0001; wkup_clear=4'b0001 -> wkup_pend[0]=0, wkup_ovf[0]=0, FSM in IDLE the next edge.
REQ-037 Ack and a new edge on the served channel in the same cycle -> wkup_pend bit stays 1 and the request reasserts after 1 idle cycle.
REQ-038 Sync off, falling selected on channel 1 -> wkup_pend[1]=1 one edge after the 1->0 transition; with wkup_en[1]=0 -> no capture.
